retinex_vout: RTL and testbench
===============================

# retinex_vout

Downstream sink for the Retinex enhancement stream: takes the raw `dst_valid`/`dst_data` pixel stream, which has no blanking and no backpressure, and buffers it in a show-ahead FIFO. It then re-emits the pixels on standard raster video timing (`hs`/`vs`/`de`) for the display encoder. It owns frame alignment, underflow/overflow detection and automatic resynchronisation. Single clock domain; the pixel clock is `clk`.

## Interface
- WIDTH, 1920, active pixels per line (matches upstream)
- HEIGHT, 1080, active lines per frame
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal porch and sync lengths, in clocks
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical porch and sync lengths, in lines
- FIFO_DEPTH, 4096, FIFO entries; must be a power of two and ≥ 2·WIDTH
- START_LEVEL, 1920, FIFO fill required before output starts
- SYNC_POL, 1, 1 = active-high `hs`/`vs`, 0 = active-low
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- src_valid  in  1  input pixel strobe, from upstream `dst_valid`
- src_data  in  24  input RGB pixel, {B,G,R} bytes as produced upstream
- vid_hs  out  1  horizontal sync
- vid_vs  out  1  vertical sync
- vid_de  out  1  data enable
- vid_data  out  24  output pixel; 0 whenever `vid_de` = 0
- running  out  1  high while in RUN
- err_underflow  out  1  sticky; cleared only by reset
- err_overflow  out  1  sticky; cleared only by reset

## Operation
- **Input pixel counter** (0..WIDTH·HEIGHT−1)
  - Increments on each `src_valid` and wraps to 0.
  - The pixel written while the counter = 0 carries a SOF tag. The FIFO word is {sof, data}, 25 bits.
  - The first pixel after reset is the start of a frame.
- **FIFO write:** a write occurs on `src_valid` when the FIFO is not full.
  - If the FIFO is full, the pixel is dropped, `err_overflow` is set and `resync_req` is set.
  - The input counter still advances on a dropped pixel.
- **State machine** (states WAIT_SOF, PRIME, RUN):
  - WAIT_SOF: pop and discard every head entry whose SOF tag is 0. When the head carries SOF → PRIME.
  - PRIME: no pops. When fill ≥ START_LEVEL → RUN, with the timing counters at (h = 0, v = 0).
  - RUN: timing runs free.
    - At the last clock of the frame (h = H_TOTAL−1, v = V_TOTAL−1): if `resync_req` = 1, go to WAIT_SOF and clear `resync_req`; otherwise stay in RUN.
- **Timing counters (RUN only):**
  - H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP; V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP.
  - h runs 0..H_TOTAL−1; v advances when h wraps.
  - Active region: h < WIDTH and v < HEIGHT. Front porch follows, then sync, then back porch.
  - hs asserted for WIDTH+H_FP ≤ h < WIDTH+H_FP+H_SYNC. vs uses the analogous rule on v, for full lines.
- **FIFO pop:** one pop per active clock when the FIFO is non-empty.
  - If the FIFO is empty during an active clock: output 0, set `err_underflow` and `resync_req`.
  - If the popped word at (0,0) has SOF = 0, or a word with SOF = 1 is popped at any position other than (0,0): still output the data, set `resync_req`.
- If a write and a pop occur in the same clock, the fill level is unchanged. This holds at full too: a write at full that coincides with a pop is accepted.
- Outside RUN, all `vid_*` outputs are idle: de = 0, data = 0, hs and vs inactive (= ~SYNC_POL).

## Timing
- All outputs are registered.
  - `vid_*` reflect the counter state of the previous clock, so latency is 1 clock from the counter to the pins.
  - Pixel data reaches `vid_data` 1 clock after its pop.
- Reset values:
  - `vid_de`, `vid_data`, `running`, `err_*` = 0; `vid_hs` and `vid_vs` = ~SYNC_POL.
  - State = WAIT_SOF; FIFO is empty; all counters = 0.
- The FIFO is show-ahead: the head word is valid combinationally whenever the FIFO is non-empty.
- Minimum latency from the first `src_valid` to the first `vid_de`: START_LEVEL + 2 clocks, when input arrives at one pixel per clock.
- Reset asserted mid-frame flushes everything. After release, the block treats the next input pixel as SOF, so upstream must also be reset.
- A `resync_req` raised during the last frame clock itself takes effect at the end of the next frame.

## Structure
- Shared package `video_pkg`:
  - Holds the 1080p60 timing constants and the `H_TOTAL`/`V_TOTAL` derivation functions.
  - Holds the state encoding localparams WAIT_SOF = 0, PRIME = 1, RUN = 2.
- Sub-module `sync_fifo`:
  - Generic parameterised WIDTH/DEPTH, show-ahead.
  - Provides `full`, `empty` and `fill_level` outputs.
  - Instantiated here with a data width of 25.

## Test plan
- **Small frame bring-up.** Parameters: WIDTH = 8, HEIGHT = 4, H_FP = H_SYNC = H_BP = 2, all V parameters = 1, START_LEVEL = 8. Stimulus: a continuous ramp of 0..31. Required response: `running` rises after 8 writes; the first `vid_de` shows pixel 0; each line has 8 de clocks then 6 blanking clocks; hs is high at h = 10..11.
- **Frame continuity.** Feed 3 frames at the average line rate. Required response: output pixel order is identical to input, and both `err_*` stay 0.
- **Underflow.** Stall input for 20 clocks mid-frame. Required response: `vid_data` = 0 on the starved de clocks and `err_underflow` = 1. At the frame end, state goes to WAIT_SOF; the next output frame starts on a SOF pixel.
- **Overflow.** Use FIFO_DEPTH = 16 and keep output in PRIME with START_LEVEL = 16, then burst 20 pixels. Required response: 4 pixels are dropped, `err_overflow` = 1, and a resync occurs after the first frame.
- **Reset mid-RUN.** Assert rst_n low at h = 3. Required response: the next clock shows de = 0, data = 0 and sync at ~SYNC_POL; the block restarts cleanly on new input.
- **SYNC_POL = 0.** Required response: hs and vs are inverted relative to the bring-up case; de and data are unchanged.

Source files
------------

// File: rtl/video_pkg.sv
// Shared raster timing constants (1080p60), blanking-total helpers and the
// output state encoding used by the video sink.
package video_pkg;

    localparam int unsigned VID_H_ACTIVE = 1920;
    localparam int unsigned VID_H_FP     = 88;
    localparam int unsigned VID_H_SYNC   = 44;
    localparam int unsigned VID_H_BP     = 148;
    localparam int unsigned VID_V_ACTIVE = 1080;
    localparam int unsigned VID_V_FP     = 4;
    localparam int unsigned VID_V_SYNC   = 5;
    localparam int unsigned VID_V_BP     = 36;

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] PRIME    = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;

    typedef enum logic [1:0] {
        StWaitSof = WAIT_SOF,
        StPrime   = PRIME,
        StRun     = RUN
    } state_e;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on rd_data whenever
// the FIFO is non-empty. A write while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_rd, do_wr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign full       = (fill_level == (AW + 1)'(DEPTH));
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign do_rd      = rd_en && !empty;
    assign do_wr      = wr_en && (!full || do_rd);
    assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/retinex_vout.sv
// Retinex stream sink: buffers unblanked pixels and replays them on raster
// hs/vs/de timing, flagging under/overflow and realigning on frame start.
module retinex_vout
    import video_pkg::*;
#(
    parameter int unsigned WIDTH       = VID_H_ACTIVE,
    parameter int unsigned HEIGHT      = VID_V_ACTIVE,
    parameter int unsigned H_FP        = VID_H_FP,
    parameter int unsigned H_SYNC      = VID_H_SYNC,
    parameter int unsigned H_BP        = VID_H_BP,
    parameter int unsigned V_FP        = VID_V_FP,
    parameter int unsigned V_SYNC      = VID_V_SYNC,
    parameter int unsigned V_BP        = VID_V_BP,
    parameter int unsigned FIFO_DEPTH  = 4096,
    parameter int unsigned START_LEVEL = 1920,
    parameter bit          SYNC_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        src_valid,
    input  logic [23:0] src_data,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_de,
    output logic [23:0] vid_data,
    output logic        running,
    output logic        err_underflow,
    output logic        err_overflow
);

    localparam int unsigned HTotal = h_total(WIDTH, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal = v_total(HEIGHT, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW     = $clog2(HTotal);
    localparam int unsigned VW     = $clog2(VTotal);
    localparam int unsigned PixW   = $clog2(WIDTH * HEIGHT);
    localparam int unsigned FillW  = $clog2(FIFO_DEPTH) + 1;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [PixW-1:0] in_cnt_q, in_cnt_d;
    logic            resync_q, resync_d;
    logic            uf_q, uf_d, of_q, of_d;
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, running_q;
    logic [23:0]     data_q, data_d;

    logic             fifo_full, fifo_empty, pop, drop, req;
    logic [FillW-1:0] fifo_fill;
    logic [24:0]      fifo_rdata;
    logic             head_sof, active, frame_start, frame_last, h_sync_zone, v_sync_zone;

    sync_fifo #(
        .WIDTH (25),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (src_valid),
        .wr_data    ({in_cnt_q == '0, src_data}),
        .rd_en      (pop),
        .rd_data    (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .fill_level (fifo_fill)
    );

    assign head_sof    = fifo_rdata[24];
    assign active      = (h_q < HW'(WIDTH)) && (v_q < VW'(HEIGHT));
    assign frame_start = (h_q == '0) && (v_q == '0);
    assign frame_last  = (h_q == HW'(HTotal - 1)) && (v_q == VW'(VTotal - 1));
    assign h_sync_zone = (h_q >= HW'(WIDTH + H_FP)) && (h_q < HW'(WIDTH + H_FP + H_SYNC));
    assign v_sync_zone = (v_q >= VW'(HEIGHT + V_FP)) && (v_q < VW'(HEIGHT + V_FP + V_SYNC));
    // A write at full is only lost when no pop frees the head slot this clock.
    assign drop        = src_valid && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        pop     = 1'b0;
        req     = 1'b0;
        uf_d    = uf_q;
        de_d    = 1'b0;
        data_d  = '0;
        hs_d    = ~SYNC_POL;
        vs_d    = ~SYNC_POL;

        unique case (state_q)
            StWaitSof: begin
                if (!fifo_empty) begin
                    if (head_sof) state_d = StPrime;
                    else          pop     = 1'b1;
                end
            end
            StPrime: begin
                if (fifo_fill >= FillW'(START_LEVEL)) state_d = StRun;
            end
            StRun: begin
                de_d = active;
                hs_d = h_sync_zone ? SYNC_POL : ~SYNC_POL;
                vs_d = v_sync_zone ? SYNC_POL : ~SYNC_POL;
                if (active) begin
                    if (fifo_empty) begin
                        uf_d = 1'b1;
                        req  = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        data_d = fifo_rdata[23:0];
                        if (head_sof != frame_start) req = 1'b1;
                    end
                end
                if (h_q == HW'(HTotal - 1)) begin
                    h_d = '0;
                    if (v_q == VW'(VTotal - 1)) begin
                        v_d = '0;
                        if (resync_q) state_d = StWaitSof;
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            default: state_d = StWaitSof;
        endcase

        if (drop) req = 1'b1;
        of_d = of_q | drop;
        // Only a request pending before the last clock is consumed there.
        resync_d = ((state_q == StRun) && frame_last && resync_q) ? req : (resync_q | req);

        in_cnt_d = in_cnt_q;
        if (src_valid) begin
            in_cnt_d = (in_cnt_q == PixW'(WIDTH * HEIGHT - 1)) ? '0 : in_cnt_q + PixW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWaitSof;
            h_q       <= '0;
            v_q       <= '0;
            in_cnt_q  <= '0;
            resync_q  <= 1'b0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            de_q      <= 1'b0;
            data_q    <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            in_cnt_q  <= in_cnt_d;
            resync_q  <= resync_d;
            uf_q      <= uf_d;
            of_q      <= of_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            data_q    <= data_d;
            running_q <= (state_d == StRun);
        end
    end

    assign vid_hs        = hs_q;
    assign vid_vs        = vs_q;
    assign vid_de        = de_q;
    assign vid_data      = data_q;
    assign running       = running_q;
    assign err_underflow = uf_q;
    assign err_overflow  = of_q;

endmodule

// File: tb/tb_retinex_vout.sv
// Bench for retinex_vout on a tiny 8x4 raster: a queue-based frame model checks
// both sync polarities every clock, plus pinned expectations per scenario.
module tb_retinex_vout;

    localparam int unsigned W = 8, H = 4, HFP = 2, HSY = 2, HBP = 2;
    localparam int unsigned VFP = 1, VSY = 1, VBP = 1, DEPTH = 16, START = 8;
    localparam int HT = W + HFP + HSY + HBP;
    localparam int VT = H + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n;
    logic src_valid;
    logic [23:0] src_data;
    logic vid_hs, vid_vs, vid_de, running, err_underflow, err_overflow;
    logic [23:0] vid_data;
    logic n_hs, n_vs, n_de, n_running, n_uf, n_of;
    logic [23:0] n_data;

    always #5 clk = ~clk;

    retinex_vout #(
        .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FIFO_DEPTH(DEPTH), .START_LEVEL(START),
        .SYNC_POL(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
        .running(running), .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    retinex_vout #(
        .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FIFO_DEPTH(DEPTH), .START_LEVEL(START),
        .SYNC_POL(1'b0)
    ) u_dut_neg (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .vid_hs(n_hs), .vid_vs(n_vs), .vid_de(n_de), .vid_data(n_data),
        .running(n_running), .err_underflow(n_uf), .err_overflow(n_of)
    );

    int n_checks = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct packed {
        logic        sof;
        logic [23:0] d;
    } word_t;

    word_t mq[$];
    int    mmode;      // 0 waiting for frame start, 1 priming, 2 displaying
    int    mpos;       // raster position within the displayed frame
    int    min_cnt;
    bit    mresync, muf, mof;
    logic  exp_de, exp_hs, exp_vs, exp_run, exp_uf, exp_of;
    logic [23:0] exp_data;

    task automatic model_reset();
        mq.delete();
        mmode = 0; mpos = 0; min_cnt = 0;
        mresync = 0; muf = 0; mof = 0;
        exp_de = 0; exp_hs = 0; exp_vs = 0; exp_run = 0; exp_uf = 0; exp_of = 0;
        exp_data = '0;
    endtask

    task automatic model_step(input logic v, input logic [23:0] d);
        bit    pop = 0, req = 0;
        int    nmode = mmode;
        int    size0 = mq.size();
        int    h, ln;
        word_t w;
        exp_de = 0; exp_data = '0; exp_hs = 0; exp_vs = 0;
        if (mmode == 0) begin
            if (size0 > 0) begin
                if (mq[0].sof) nmode = 1;
                else           pop = 1;
            end
        end else if (mmode == 1) begin
            if (size0 >= START) nmode = 2;
        end else begin
            h  = mpos % HT;
            ln = mpos / HT;
            exp_hs = (h >= W + HFP) && (h < W + HFP + HSY);
            exp_vs = (ln >= H + VFP) && (ln < H + VFP + VSY);
            if (h < W && ln < H) begin
                exp_de = 1;
                if (size0 == 0) begin
                    muf = 1; req = 1;
                end else begin
                    pop = 1;
                    exp_data = mq[0].d;
                    if (mq[0].sof != (mpos == 0)) req = 1;
                end
            end
            if (mpos == FRAME - 1) begin
                mpos = 0;
                if (mresync) begin
                    nmode = 0; mresync = 0;
                end
            end else begin
                mpos++;
            end
        end
        if (pop) void'(mq.pop_front());
        if (v) begin
            if (size0 < DEPTH || pop) begin
                w.sof = (min_cnt == 0);
                w.d   = d;
                mq.push_back(w);
            end else begin
                mof = 1; req = 1;
            end
            min_cnt = (min_cnt + 1) % (W * H);
        end
        mresync = mresync | req;
        mmode   = nmode;
        exp_run = (mmode == 2);
        exp_uf  = muf;
        exp_of  = mof;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(src_valid, src_data);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("de", vid_de, exp_de);
                check("data", vid_data, exp_data);
                check("hs", vid_hs, exp_hs);
                check("vs", vid_vs, exp_vs);
                check("running", running, exp_run);
                check("err_underflow", err_underflow, exp_uf);
                check("err_overflow", err_overflow, exp_of);
                check("neg_hs", n_hs, !exp_hs);
                check("neg_vs", n_vs, !exp_vs);
                check("neg_de", n_de, exp_de);
                check("neg_data", n_data, exp_data);
                check("neg_running", n_running, exp_run);
            end
        end
    end

    // ---------------- stimulus ----------------
    int          cyc;
    logic        rec_de [512];
    logic        rec_hs [512];
    logic        rec_run [512];
    logic        rec_uf [512];
    logic        rec_of [512];
    logic [23:0] rec_data [512];

    task automatic drive(input logic v, input logic [23:0] d);
        @(negedge clk);
        if (cyc < 512) begin
            rec_de[cyc]   = vid_de;
            rec_hs[cyc]   = vid_hs;
            rec_run[cyc]  = running;
            rec_uf[cyc]   = err_underflow;
            rec_of[cyc]   = err_overflow;
            rec_data[cyc] = vid_data;
        end
        cyc++;
        #1;
        src_valid = v;
        src_data  = d;
    endtask

    task automatic do_reset();
        src_valid = 0;
        src_data  = '0;
        rst_n     = 0;
        chk_en    = 1;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1;
        cyc   = 0;
    endtask

    // Input pacing matching the output's average line rate.
    function automatic logic pat(input int p);
        return ((p % HT) < W) && (((p % FRAME) / HT) < H);
    endfunction

    int ip;

    initial begin
        rst_n = 1; src_valid = 0; src_data = '0; cyc = 0;
        @(negedge clk);
        #1;

        // Bring-up: continuous ramp 0..31.
        do_reset();
        for (int k = 0; k < 40; k++) drive(k < 32, (k < 32) ? 24'(k) : 24'd0);
        check("bringup_running_before", rec_run[8], 0);
        check("bringup_running_rise", rec_run[9], 1);
        check("bringup_de_before", rec_de[9], 0);
        check("bringup_first_de", rec_de[10], 1);
        check("bringup_first_pixel", rec_data[10], 0);
        check("bringup_second_pixel", rec_data[11], 1);
        check("bringup_last_pixel_line0", rec_data[17], 7);
        check("bringup_blank_start", rec_de[18], 0);
        check("bringup_blank_end", rec_de[23], 0);
        check("bringup_line1_de", rec_de[24], 1);
        check("bringup_line1_pixel", rec_data[24], 8);
        check("bringup_hs_h9", rec_hs[19], 0);
        check("bringup_hs_h10", rec_hs[20], 1);
        check("bringup_hs_h11", rec_hs[21], 1);
        check("bringup_hs_h12", rec_hs[22], 0);
        repeat (200) drive(0, '0);
        check("bringup_starved_uf", err_underflow, 1);
        check("bringup_no_of", err_overflow, 0);

        // Continuity over three frames, then reset at h = 3 of the fourth.
        do_reset();
        for (int k = 0; k <= 306; k++) drive(pat(k), 24'($urandom));
        check("cont_no_uf", rec_uf[306], 0);
        check("cont_no_of", rec_of[306], 0);
        check("pre_reset_de", rec_de[306], 1);
        rst_n = 0;
        @(negedge clk);
        check("rst_de", vid_de, 0);
        check("rst_data", vid_data, 0);
        check("rst_hs", vid_hs, 0);
        check("rst_vs", vid_vs, 0);
        check("rst_neg_hs", n_hs, 1);
        check("rst_running", running, 0);

        // Underflow: 20-clock input stall mid-frame.
        do_reset();
        ip = 0;
        for (int k = 0; k < 250; k++) begin
            if (k >= 40 && k < 60) drive(0, '0);
            else begin
                drive(pat(ip), 24'($urandom));
                ip++;
            end
        end
        check("uf_before", rec_uf[51], 0);
        check("uf_flag", rec_uf[52], 1);
        check("uf_starved_de", rec_de[52], 1);
        check("uf_starved_data", rec_data[52], 0);
        check("uf_run_last_clock", rec_run[106], 1);
        check("uf_resync_wait", rec_run[107], 0);
        check("uf_restart", rec_run[200], 1);

        // Overflow: 36-pixel burst drops 32..35.
        do_reset();
        for (int k = 0; k < 150; k++) drive(k < 36, 24'(k + 100));
        check("of_before", rec_of[32], 0);
        check("of_flag", rec_of[33], 1);
        check("of_frame0_pixel31", rec_data[52 + 7], 131);
        check("of_run_last_clock", rec_run[106], 1);
        check("of_resync_wait", rec_run[107], 0);

        // Random pacing and data.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if (k < 400) drive($urandom_range(0, 99) < 33, 24'($urandom));
            else         drive($urandom_range(0, 99) < 60, 24'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
